// File: rtl/core_pkg.sv
// Shared core definitions: register-address width, the x0 index and the hazard control bundle.
package core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_flush;
  } hazard_ctrl_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall and flush cycle counters; wrap silently and clear asynchronously on reset.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_inc_i) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush_inc_i) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall and branch-flush control between ID and EX; zero-latency combinational outputs.
// Performance counters exist only when HAZARD_UNIT_PERF_CNT_EN is defined, otherwise they read 0.
module hazard_unit
  import core_pkg::*;
#(
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [REG_ADDR_W-1:0] rs1_addr_id_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_id_i,
  input  logic                  id_ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] id_ex_rd_i,
  input  logic                  flush_req_i,
  output logic                  pc_write_en_o,
  output logic                  if_id_write_en_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  logic         w_load_use;
  hazard_ctrl_t w_ctrl;

  // A load to x0 produces nothing, so it can never be a real dependency.
  assign w_load_use = id_ex_mem_read_i
                    && (id_ex_rd_i != REG_ADDR_W'(REG_X0))
                    && ((id_ex_rd_i == rs1_addr_id_i) || (id_ex_rd_i == rs2_addr_id_i));

  // Flush beats the stall: the dependent instruction is on the wrong path anyway.
  always_comb begin
    w_ctrl = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
    if (flush_req_i) begin
      w_ctrl = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
    end else if (w_load_use) begin
      w_ctrl = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
    end
  end

  assign pc_write_en_o    = w_ctrl.pc_en;
  assign if_id_write_en_o = w_ctrl.ifid_en;
  assign if_id_flush_o    = w_ctrl.ifid_flush;
  assign id_ex_flush_o    = w_ctrl.idex_flush;

`ifdef HAZARD_UNIT_PERF_CNT_EN
  hazard_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .stall_inc_i (w_load_use && !flush_req_i),
    .flush_inc_i (flush_req_i),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );
`else
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk_i ^ rst_ni;
  assign stall_cnt_o      = '0;
  assign flush_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed vectors feed a scoreboard queue; an independent monitor pops and compares each cycle.
module tb_hazard_unit;

  localparam int CNT_W = 32;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [4:0]       rs1_addr_id_i;
  logic [4:0]       rs2_addr_id_i;
  logic             id_ex_mem_read_i;
  logic [4:0]       id_ex_rd_i;
  logic             flush_req_i;
  logic             pc_write_en_o;
  logic             if_id_write_en_o;
  logic             if_id_flush_o;
  logic             id_ex_flush_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  always #5 clk_i = ~clk_i;

  hazard_unit #(
    .REG_ADDR_W (5),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .rs1_addr_id_i    (rs1_addr_id_i),
    .rs2_addr_id_i    (rs2_addr_id_i),
    .id_ex_mem_read_i (id_ex_mem_read_i),
    .id_ex_rd_i       (id_ex_rd_i),
    .flush_req_i      (flush_req_i),
    .pc_write_en_o    (pc_write_en_o),
    .if_id_write_en_o (if_id_write_en_o),
    .if_id_flush_o    (if_id_flush_o),
    .id_ex_flush_o    (id_ex_flush_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
  );

`ifdef HAZARD_UNIT_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]       ctrl;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t             sb_q[$];
  logic             sample_vld = 1'b0;
  logic             drain_req  = 1'b0;
  logic             drain_done = 1'b0;
  int               n_vec      = 0;
  int               n_miss     = 0;
  logic [CNT_W-1:0] m_sc       = '0;
  logic [CNT_W-1:0] m_fc       = '0;

  // Expected ctrl is {pc_en, ifid_en, ifid_flush, idex_flush}, worked out by hand per vector.
  task automatic apply(input logic rn, input logic [4:0] a1, input logic [4:0] a2,
                       input logic mr, input logic [4:0] rd, input logic fl,
                       input logic [3:0] exp_ctrl);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_ni           = rn;
    rs1_addr_id_i    = a1;
    rs2_addr_id_i    = a2;
    id_ex_mem_read_i = mr;
    id_ex_rd_i       = rd;
    flush_req_i      = fl;
    sample_vld       = 1'b1;
    if (!rn) begin
      m_sc = '0;
      m_fc = '0;
    end
    e.ctrl = exp_ctrl;
    e.sc   = PERF ? m_sc : '0;
    e.fc   = PERF ? m_fc : '0;
    sb_q.push_back(e);
    // This vector is still on the inputs at the next rising edge, where the counters sample it.
    if (rn) begin
      if (fl) m_fc = m_fc + 1'b1;
      else if (exp_ctrl == 4'b0001) m_sc = m_sc + 1'b1;
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    logic [3:0] act;
    if (sample_vld) begin
      if (sb_q.size() == 0) begin
        n_miss++;
        $display("FAIL sb_underflow: monitor saw output with empty queue at vector %0d", n_vec);
      end else begin
        e   = sb_q.pop_front();
        act = {pc_write_en_o, if_id_write_en_o, if_id_flush_o, id_ex_flush_o};
        if (act !== e.ctrl) begin
          n_miss++;
          $display("FAIL ctrl v%0d: got %b expected %b", n_vec, act, e.ctrl);
        end
        if (stall_cnt_o !== e.sc) begin
          n_miss++;
          $display("FAIL stall_cnt v%0d: got %0d expected %0d", n_vec, stall_cnt_o, e.sc);
        end
        if (flush_cnt_o !== e.fc) begin
          n_miss++;
          $display("FAIL flush_cnt v%0d: got %0d expected %0d", n_vec, flush_cnt_o, e.fc);
        end
        n_vec++;
      end
    end else if (drain_req && !drain_done) begin
      if (sb_q.size() != 0) begin
        n_miss++;
        $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
      end
      drain_done = 1'b1;
    end
  end

  initial begin
    rst_ni           = 1'b0;
    rs1_addr_id_i    = '0;
    rs2_addr_id_i    = '0;
    id_ex_mem_read_i = 1'b0;
    id_ex_rd_i       = '0;
    flush_req_i      = 1'b0;

    //     rst   rs1    rs2    ld    rd     fl    expected
    apply(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 4'b1100); // reset: outputs unaffected
    apply(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 4'b1100); // normal
    apply(1'b1, 5'd1, 5'd2, 1'b1, 5'd1, 1'b0, 4'b0001); // load-use on rs1
    apply(1'b1, 5'd1, 5'd2, 1'b1, 5'd2, 1'b0, 4'b0001); // load-use on rs2
    apply(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b0, 4'b1100); // independent load
    apply(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 4'b1100); // load to x0
    apply(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b1111); // flush
    apply(1'b1, 5'd1, 5'd2, 1'b1, 5'd1, 1'b1, 4'b1111); // flush wins over hazard
    apply(1'b1, 5'd7, 5'd9, 1'b1, 5'd9, 1'b0, 4'b0001); // third stall
    apply(1'b1, 5'd1, 5'd0, 1'b1, 5'd0, 1'b0, 4'b1100); // x0 load, rs2=x0
    apply(1'b1, 5'd4, 5'd4, 1'b0, 5'd4, 1'b0, 4'b1100); // non-load producer
    apply(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 4'b1100); // counters read 3 / 2
    apply(1'b1, 5'd3, 5'd8, 1'b1, 5'd3, 1'b0, 4'b0001); // stall just before reset
    apply(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 4'b1100); // mid-run reset clears at once
    apply(1'b1, 5'd6, 5'd2, 1'b1, 5'd6, 1'b0, 4'b0001); // count restarts from 0
    apply(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 4'b1111); // flush after reset
    apply(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 4'b1100); // counters read 1 / 1

    @(posedge clk_i);
    #1;
    sample_vld = 1'b0;
    drain_req  = 1'b1;
    repeat (4) @(posedge clk_i);
    if (!drain_done) begin
      n_miss++;
      $display("FAIL drain_timeout: monitor did not finish, expected done");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
